uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial receive front end for the CPU's UART MMIO path. Takes the raw `rxd` pin, oversamples it on the system clock, and deframes 8N1 characters. Completed bytes are buffered in a small FIFO that the CPU's serial-status/data registers pop. It sits directly upstream of the CPU's UART read port, between the board pin and the core.

## Interface
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in baud.
- `FIFO_DEPTH`, default 8: number of buffered bytes. Must be a power of two, ≥2.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: one clock; reset is asynchronous and active-high.
- `rxd` input 1: raw serial line, asynchronous, idle high.
- `rd_en_i` input 1: pop the FIFO head this cycle.
- `data_o` output 8: FIFO head byte, first-word fall-through.
- `data_valid_o` output 1: FIFO non-empty.
- `count_o` output $clog2(FIFO_DEPTH)+1: bytes currently held.
- `overrun_o` output 1: sticky flag; a byte was dropped because the FIFO was full.
- `frame_err_o` output 1: sticky flag; a stop bit was sampled low.
- `clr_err_i` input 1: clears both sticky flags.

## Operation
- Derived constants: DIV = CLK_FREQ/BAUD (integer division) and HALF = DIV/2. The baud counter width is $clog2(DIV).
- `rxd` passes through a 2-FF synchronizer, giving `rxd_s`. All decisions use `rxd_s`.
- FSM states:
  - IDLE: when `rxd_s`==0, clear the counter and go to START.
  - START: the counter runs to HALF-1. At that cycle, if `rxd_s`==0, clear the counter, set bit index 0 and go to DATA. Otherwise treat it as a glitch and return to IDLE.
  - DATA: the counter runs to DIV-1. At that cycle, sample `rxd_s` into shift bit 7, shift right (LSB first), clear the counter and increment the bit index. After the 8th bit, go to STOP.
  - STOP: the counter runs to DIV-1 and `rxd_s` is sampled. If it is 1, push the byte and go to IDLE. If it is 0, discard the byte, set `frame_err_o` and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxd_s`==1, then go to IDLE. This prevents a break condition from retriggering.
- FIFO behaviour:
  - Pop with `rd_en_i` while empty: ignored, no state change.
  - Push while full with no pop in the same cycle: the byte is dropped and `overrun_o` is set. The FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, the count is unchanged and no overrun is flagged.
  - Push and pop in the same cycle while empty: the push is stored and the pop is ignored.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Sticky flags:
  - If `clr_err_i` coincides with a new error event, the flag stays set (set wins).

## Timing
- Reset values: FSM in IDLE, counter 0, `data_valid_o`=0, `count_o`=0, `data_o`=0 (storage cleared), `overrun_o`=0, `frame_err_o`=0. Synchronizer flops reset to 1.
- Synchronizer latency is 2 cycles from the `rxd` edge to `rxd_s`.
- The push is registered on the stop-bit sample edge. `data_valid_o` and `count_o` update in the following cycle.
- `data_o` is combinational from storage at the read pointer. After `rd_en_i` at edge N, the next byte is valid after edge N.
- Reset asserted mid-frame aborts the frame immediately; no partial byte is pushed. After release, the FSM waits in IDLE for a new falling edge.

## Structure
- A shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - the 8-bit data-width constant.
- One sub-module, `sync_fifo`, parameterised by width and depth. Its ports are push, pop, din, dout, count, full and empty.
- The deframer FSM, baud counter and sticky flags live in the top module.

## Test plan
Bench parameters: CLK_FREQ=16, BAUD=1, so DIV=16 and HALF=8. One bit period is 16 clocks.
- Send frame 0x55 with a correct stop bit -> `data_valid_o`=1 and `data_o`=0x55 the cycle after the stop sample. `count_o`=1. Pulse `rd_en_i` -> `data_valid_o`=0 and `count_o`=0.
- Drive `rxd` low for 5 clocks, then high -> no byte pushed, FSM back in IDLE, both flags 0.
- Send 9 bytes 0x01..0x09 with no reads -> `count_o`=8 and `overrun_o`=1. Popping returns 0x01..0x08 in order; 0x09 is lost.
- Send 0xA5 with the stop bit low, then hold `rxd` low for 40 clocks -> no push and `frame_err_o`=1. No new frame starts until `rxd` returns high. `clr_err_i` -> `frame_err_o`=0.
- With the FIFO full, assert `rd_en_i` on the same edge as the 9th byte's push -> `count_o` stays 8, `overrun_o`=0, and the head advances to the 2nd byte.
- Assert `rst` during DATA bit 4 of 0x3C -> all outputs at their reset values and no push. The next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: pin synchronizer, deframer FSM,
// sticky error flags and a receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxd,
  input  logic                        rd_en_i,
  output logic [DATA_W-1:0]           data_o,
  output logic                        data_valid_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        overrun_o,
  output logic                        frame_err_o,
  input  logic                        clr_err_i
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]        sync_q;
  logic              rxd_s;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              bit_end;
  logic              half_end;
  logic              push;
  logic              frame_ev;
  logic              ovf_ev;
  logic              full;
  logic              empty;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxd};
  end

  assign bit_end  = (cnt == CW'(DIV - 1));
  assign half_end = (cnt == CW'(HALF - 1));
  assign push     = (state == STOP) && bit_end && rxd_s;
  assign frame_ev = (state == STOP) && bit_end && !rxd_s;
  assign ovf_ev   = push && full && !rd_en_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rxd_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (half_end) begin
            cnt <= '0;
            if (!rxd_s) begin
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shift   <= {rxd_s, shift[DATA_W-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= rxd_s ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // Hold off until the line recovers so a break is one error.
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (ovf_ev)         overrun_o <= 1'b1;
      else if (clr_err_i) overrun_o <= 1'b0;
      if (frame_ev)       frame_err_o <= 1'b1;
      else if (clr_err_i) frame_err_o <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rd_en_i),
    .din   (shift),
    .dout  (data_o),
    .count (count_o),
    .full  (full),
    .empty (empty)
  );

  assign data_valid_o = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed corner cases, a frame table
// and random frames against a queue model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rd_en_i;
  logic       clr_err_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic [3:0] count_o;
  logic       overrun_o;
  logic       frame_err_o;

  int tests = 0;
  int fails = 0;

  uart_rx_fifo #(
    .CLK_FREQ   (16),
    .BAUD       (1),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rxd          (rxd),
    .rd_en_i      (rd_en_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .count_o      (count_o),
    .overrun_o    (overrun_o),
    .frame_err_o  (frame_err_o),
    .clr_err_i    (clr_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_count;
    bit         exp_ferr;
    logic [7:0] exp_head;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One 8N1 frame, 16 clocks per bit; optional one-cycle pop at pop_cyc,
  // optional early cut-off after ncyc clocks, optional low tail.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int pop_cyc, input int ncyc,
                            input int low_tail);
    for (int i = 0; i < ncyc; i++) begin
      int k;
      k = i / 16;
      if (k == 0)      rxd = 1'b0;
      else if (k <= 8) rxd = b[k-1];
      else             rxd = stop_ok;
      rd_en_i = (i == pop_cyc);
      tick();
    end
    rd_en_i = 1'b0;
    for (int i = 0; i < low_tail; i++) begin
      rxd = 1'b0;
      tick();
    end
    rxd = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1, -1, 160, 0);
    idle(4);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, data_o, exp);
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, data_valid_o, 0);
    check({tag, "_count"}, count_o, 0);
    check({tag, "_data"}, data_o, 0);
    check({tag, "_ovr"}, overrun_o, 0);
    check({tag, "_ferr"}, frame_err_o, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs [4];
    logic [7:0] q [$];
    bit         m_ovr;
    bit         m_ferr;

    rst = 1'b1; rxd = 1'b1; rd_en_i = 1'b0; clr_err_i = 1'b0;
    tick(); tick();
    check_reset_state("reset");
    rst = 1'b0;
    idle(4);

    // Single good frame then pop
    send_frame(8'h55, 1'b1, -1, 160, 0);
    check("f55_valid", data_valid_o, 1);
    check("f55_data", data_o, 8'h55);
    check("f55_count", count_o, 1);
    idle(4);
    rd_en_i = 1'b1; tick(); rd_en_i = 1'b0;
    check("f55_pop_valid", data_valid_o, 0);
    check("f55_pop_count", count_o, 0);

    // Start-bit glitch
    rxd = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    idle(40);
    check("glitch_count", count_o, 0);
    check("glitch_ovr", overrun_o, 0);
    check("glitch_ferr", frame_err_o, 0);
    send(8'h5A);
    check("after_glitch_count", count_o, 1);
    pop_check("after_glitch_data", 8'h5A);

    // Overrun: 9 bytes without reads
    for (int i = 1; i <= 9; i++) send(8'(i));
    check("ovr_count", count_o, 8);
    check("ovr_flag", overrun_o, 1);
    for (int i = 1; i <= 8; i++) pop_check("ovr_order", 8'(i));
    check("ovr_drained", data_valid_o, 0);
    pulse_clr();
    check("ovr_clr", overrun_o, 0);

    // Framing error followed by a held-low line
    send_frame(8'hA5, 1'b0, -1, 160, 40);
    check("ferr_flag", frame_err_o, 1);
    idle(200);
    check("ferr_no_push", count_o, 0);
    pulse_clr();
    check("ferr_clr", frame_err_o, 0);
    send(8'h3E);
    pop_check("ferr_recover", 8'h3E);

    // Frame table
    vecs[0] = '{8'h81, 1'b1, 1, 1'b0, 8'h81};
    vecs[1] = '{8'hA5, 1'b0, 1, 1'b1, 8'h81};
    vecs[2] = '{8'h00, 1'b1, 2, 1'b1, 8'h81};
    vecs[3] = '{8'hFF, 1'b1, 3, 1'b1, 8'h81};
    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].stop_ok, -1, 160, 0);
      idle(20);
      check("tbl_count", count_o, vecs[i].exp_count);
      check("tbl_ferr", frame_err_o, vecs[i].exp_ferr);
      check("tbl_head", data_o, vecs[i].exp_head);
    end
    pop_check("tbl_pop0", 8'h81);
    pop_check("tbl_pop1", 8'h00);
    pop_check("tbl_pop2", 8'hFF);
    pulse_clr();

    // Push and pop on the same edge while full
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
    check("full_count", count_o, 8);
    check("full_head", data_o, 8'h11);
    send_frame(8'h19, 1'b1, 154, 160, 0);
    idle(4);
    check("simul_count", count_o, 8);
    check("simul_ovr", overrun_o, 0);
    for (int i = 0; i < 8; i++) pop_check("simul_order", 8'h12 + 8'(i));
    check("simul_empty", data_valid_o, 0);

    // Reset in the middle of DATA bit 4
    send(8'h77);
    send_frame(8'h3C, 1'b1, -1, 88, 0);
    rst = 1'b1;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    idle(30);
    check("midrst_no_push", count_o, 0);
    send(8'hC3);
    check("midrst_count", count_o, 1);
    pop_check("midrst_data", 8'hC3);

    // Random frames against a queue model
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      bit ok;
      int npop;
      b  = 8'($urandom);
      ok = ($urandom_range(7) != 0);
      send_frame(b, ok, -1, 160, 0);
      idle(20);
      if (!ok)             m_ferr = 1'b1;
      else if (q.size() < 8) q.push_back(b);
      else                 m_ovr = 1'b1;
      check("rnd_count", count_o, q.size());
      check("rnd_ovr", overrun_o, m_ovr);
      check("rnd_ferr", frame_err_o, m_ferr);
      npop = $urandom_range(3);
      for (int p = 0; p < npop; p++) begin
        if (q.size() > 0) begin
          pop_check("rnd_data", q.pop_front());
        end else begin
          rd_en_i = 1'b1; tick(); rd_en_i = 1'b0;
        end
        check("rnd_pop_count", count_o, q.size());
      end
      if ($urandom_range(4) == 0) begin
        pulse_clr();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
